// File: rtl/debounce_ctrl.sv
// debounce_ctrl: two-flop synchronizer, shared sample tick and per-channel qualification counters.
// Build option: define DEBOUNCE_RELEASE_PULSE_EN to compile in the release-pulse register.
module synchronizer #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] meta_q;
    always_ff @(posedge clk) begin
        meta_q <= d_i;
        q_o    <= meta_q;
    end
endmodule

module debounce_ctrl #(
    parameter int WIDTH          = 1,
    parameter int SAMPLE_CNT_MAX = 25000,
    parameter int PULSE_CNT_MAX  = 150
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse
);
    localparam int WC_W = $clog2(SAMPLE_CNT_MAX);
    localparam int SC_W = $clog2(PULSE_CNT_MAX + 1);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(SAMPLE_CNT_MAX - 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(PULSE_CNT_MAX - 1);

    logic [WIDTH-1:0]            s;
    logic [WC_W-1:0]             wc_q, wc_d;
    logic [WIDTH-1:0][SC_W-1:0]  sc_q, sc_d;
    logic [WIDTH-1:0]            level_q, press_q, flip;
    logic                        tick;

    synchronizer #(.WIDTH(WIDTH)) u_sync (
        .clk (clk),
        .d_i (raw_in),
        .q_o (s)
    );

    // An agreeing sample aborts qualification on any cycle, not only on ticks.
    always_comb begin
        tick = wc_q == WC_LAST;
        wc_d = tick ? '0 : wc_q + WC_W'(1);
        flip = '0;
        sc_d = sc_q;
        for (int i = 0; i < WIDTH; i++) begin
            flip[i] = (s[i] != level_q[i]) && tick && (sc_q[i] == SC_LAST);
            sc_d[i] = (s[i] == level_q[i] || flip[i]) ? '0 : tick ? sc_q[i] + SC_W'(1) : sc_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wc_q    <= '0;
            sc_q    <= '0;
            level_q <= '0;
            press_q <= '0;
        end else begin
            wc_q    <= wc_d;
            sc_q    <= sc_d;
            level_q <= level_q ^ flip;
            press_q <= flip & ~level_q;
        end
    end

`ifdef DEBOUNCE_RELEASE_PULSE_EN
    logic [WIDTH-1:0] release_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) release_q <= '0;
        else        release_q <= flip & level_q;
    end
    assign release_pulse = release_q;
`else
    assign release_pulse = '0;
`endif

    assign level       = level_q;
    assign press_pulse = press_q;
endmodule

// File: tb/tb_debounce_ctrl.sv
// tb_debounce_ctrl: directed vector table plus hand-written corner sequences
// for WIDTH=2, SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3.
module tb_debounce_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] raw_in = 2'b01;
    logic [1:0] level, press_pulse, release_pulse;
    int         tests = 0;
    int         fails = 0;
    int         edge_n = 0;

`ifdef DEBOUNCE_RELEASE_PULSE_EN
    localparam bit REL_EN = 1'b1;
`else
    localparam bit REL_EN = 1'b0;
`endif

    debounce_ctrl #(.WIDTH(2), .SAMPLE_CNT_MAX(4), .PULSE_CNT_MAX(3)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .raw_in        (raw_in),
        .level         (level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] raw;
        int         at_edge;
        logic [1:0] lvl;
        logic [1:0] prs;
        logic [1:0] rel;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s edge=%0d got=%b expected=%b", name, edge_n, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        edge_n++;
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [1:0] raw);
        rst_n  = 1'b0;
        raw_in = raw;
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        edge_n = 0;
    endtask

    initial begin
        int presses;
        vt[0] = '{2'b01, 11, 2'b00, 2'b00, 2'b00};
        vt[1] = '{2'b01, 12, 2'b01, 2'b01, 2'b00};
        vt[2] = '{2'b00, 13, 2'b01, 2'b00, 2'b00};
        vt[3] = '{2'b00, 23, 2'b01, 2'b00, 2'b00};
        vt[4] = '{2'b00, 24, 2'b00, 2'b00, REL_EN ? 2'b01 : 2'b00};
        vt[5] = '{2'b00, 25, 2'b00, 2'b00, 2'b00};
        vt[6] = '{2'b11, 35, 2'b00, 2'b00, 2'b00};
        vt[7] = '{2'b11, 36, 2'b11, 2'b11, 2'b00};
        vt[8] = '{2'b11, 37, 2'b11, 2'b00, 2'b00};

        do_reset(2'b01);
        chk("reset_level", level, 2'b00);
        chk("reset_press", press_pulse, 2'b00);
        chk("reset_release", release_pulse, 2'b00);

        // Clean press, release, then simultaneous press on both channels.
        foreach (vt[k]) begin
            raw_in = vt[k].raw;
            while (edge_n < vt[k].at_edge) step();
            chk($sformatf("vec%0d_level", k), level, vt[k].lvl);
            chk($sformatf("vec%0d_press", k), press_pulse, vt[k].prs);
            chk($sformatf("vec%0d_release", k), release_pulse, vt[k].rel);
        end

        // Asynchronous reset while level is high: outputs clear without a clock edge.
        raw_in = 2'b01;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_level", level, 2'b00);
        chk("async_rst_press", press_pulse, 2'b00);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        edge_n = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("post_rst_level", level, k == 12 ? 2'b01 : 2'b00);
            chk("post_rst_press", press_pulse, k == 12 ? 2'b01 : 2'b00);
        end

        // Bounce: sampled low at tick 8 aborts, qualification restarts at 12.
        do_reset(2'b01);
        presses = 0;
        for (int k = 1; k <= 24; k++) begin
            raw_in = (k >= 6 && k <= 9) ? 2'b00 : 2'b01;
            step();
            if (press_pulse[0]) presses++;
            if (k == 19) chk("bounce_level19", level, 2'b00);
            if (k == 20) chk("bounce_level20", level, 2'b01);
        end
        tests++;
        if (presses != 1) begin
            fails++;
            $display("FAIL bounce_press_count got=%0d expected=1", presses);
        end

        // Short glitch on channel 1, synchronized high only before edges 5 and 6.
        do_reset(2'b00);
        for (int k = 1; k <= 20; k++) begin
            raw_in = (k == 3 || k == 4) ? 2'b10 : 2'b00;
            step();
            chk("glitch_level", level, 2'b00);
            chk("glitch_press", press_pulse, 2'b00);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
